// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store unit between the ALU and the data-memory port.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned H/HU/W accesses instead of truncating them.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o,
    output logic        fault_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    state_t      state_r;
    state_t      state_s;
    logic        we_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [15:0] tmo_cnt_r;

    logic        op_we_s;
    logic [2:0]  op_funct3_s;
    logic [31:0] op_addr_s;
    logic [31:0] op_wdata_s;
    logic        fault_s;
    logic        misalign_s;
    logic        tmo_hit_s;
    logic        in_mem_s;
    logic        was_mem_s;
    logic [31:0] rdata_s;

    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001, 3'b010: is_illegal = 1'b0;
            3'b100, 3'b101:         is_illegal = we;
            default:                is_illegal = 1'b1;
        endcase
    endfunction

`ifdef LSU_MISALIGN_CHECK_EN
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b001, 3'b101: is_misaligned = a[0];
            3'b010:         is_misaligned = (a != 2'b00);
            default:        is_misaligned = 1'b0;
        endcase
    endfunction
`endif

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000, 3'b100: byte_en = 4'b0001 << a;
            3'b001, 3'b101: byte_en = 4'b0011 << {a[1], 1'b0};
            default:        byte_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  store_data = {4{d[7:0]}};
            3'b001:  store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = a[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_fmt = {{24{b[7]}}, b};
            3'b001:  load_fmt = {{16{h[15]}}, h};
            3'b010:  load_fmt = d;
            3'b100:  load_fmt = {24'd0, b};
            3'b101:  load_fmt = {16'd0, h};
            default: load_fmt = 32'd0;
        endcase
    endfunction

    // In IDLE the op is still on the inputs; afterwards the latched copy is authoritative.
    assign op_we_s     = (state_r == IDLE) ? we_i     : we_r;
    assign op_funct3_s = (state_r == IDLE) ? funct3_i : funct3_r;
    assign op_addr_s   = (state_r == IDLE) ? addr_i   : addr_r;
    assign op_wdata_s  = (state_r == IDLE) ? wdata_i  : wdata_r;

    assign in_mem_s  = (state_s == REQ) || (state_s == WAIT);
    assign was_mem_s = (state_r == REQ) || (state_r == WAIT);
    assign tmo_hit_s = (TIMEOUT_LIM != 16'd0) &&
                       (({1'b0, tmo_cnt_r} + 17'd1) >= {1'b0, TIMEOUT_LIM});

    // Next-state decode; memory responses take priority over an expiring timeout.
    always_comb begin
        state_s    = state_r;
        fault_s    = 1'b0;
        misalign_s = 1'b0;
        rdata_s    = 32'd0;
        case (state_r)
            IDLE: begin
                if (start_i) begin
                    if (is_illegal(we_i, funct3_i)) begin
                        state_s = DONE;
                        fault_s = 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
                    end else if (is_misaligned(funct3_i, addr_i[1:0])) begin
                        state_s    = DONE;
                        misalign_s = 1'b1;
`endif
                    end else begin
                        state_s = REQ;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    if (we_r) begin
                        state_s = DONE;
                    end else if (mem_rvalid_i) begin
                        state_s = DONE;
                        rdata_s = load_fmt(funct3_r, addr_r[1:0], mem_rdata_i);
                    end else begin
                        state_s = WAIT;
                    end
                end else if (tmo_hit_s) begin
                    state_s = DONE;
                    fault_s = 1'b1;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (mem_rvalid_i) begin
                    state_s = DONE;
                    rdata_s = load_fmt(funct3_r, addr_r[1:0], mem_rdata_i);
                end else if (tmo_hit_s) begin
                    state_s = DONE;
                    fault_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State, latched operation, timeout counter and all registered port drive.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            we_r        <= 1'b0;
            funct3_r    <= 3'd0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            tmo_cnt_r   <= 16'd0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            rdata_o     <= 32'd0;
            misalign_o  <= 1'b0;
            fault_o     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_be_o    <= 4'd0;
            mem_wdata_o <= 32'd0;
        end else begin
            state_r <= state_s;
            if ((state_r == IDLE) && start_i) begin
                we_r     <= we_i;
                funct3_r <= funct3_i;
                addr_r   <= addr_i;
                wdata_r  <= wdata_i;
            end
            tmo_cnt_r  <= (in_mem_s && was_mem_s) ? (tmo_cnt_r + 16'd1) : 16'd0;
            busy_o     <= (state_s != IDLE);
            done_o     <= (state_s == DONE);
            fault_o    <= fault_s;
            misalign_o <= misalign_s;
            if (state_s == DONE) begin
                rdata_o <= rdata_s;
            end
            mem_req_o <= (state_s == REQ);
            if (state_s == REQ) begin
                mem_we_o    <= op_we_s;
                mem_addr_o  <= {op_addr_s[31:2], 2'b00};
                mem_be_o    <= byte_en(op_funct3_s, op_addr_s[1:0]);
                mem_wdata_o <= op_we_s ? store_data(op_funct3_s, op_wdata_s) : 32'd0;
            end else begin
                mem_we_o    <= 1'b0;
                mem_addr_o  <= 32'd0;
                mem_be_o    <= 4'd0;
                mem_wdata_o <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a scripted memory responder.
// Expectations follow LSU_MISALIGN_CHECK_EN the same way as the design build.
module tb_lsu_ctrl;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, start, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        busy, done, misalign, fault;
    logic [31:0] rdata;
    logic        mem_req, mem_we, gnt, rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic        mis;
    } exp_t;
    exp_t sb[$];

    // observations of the most recent operation
    bit          obs_done, obs_unstable;
    int          obs_lat, obs_req_n, exp_lat;
    logic [31:0] obs_rdata, obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we, obs_fault, obs_mis;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .we_i(we), .funct3_i(f3),
        .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done), .rdata_o(rdata),
        .misalign_o(misalign), .fault_o(fault), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(mem_rdata)
    );

    function automatic logic ref_fault(input logic w, input logic [2:0] f);
        if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
        return w && f[2];
    endfunction

    function automatic logic ref_mis(input logic [2:0] f, input logic [31:0] a);
`ifdef LSU_MISALIGN_CHECK_EN
        return ((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int ref_size(input logic [2:0] f);
        if (f[1:0] == 2'd0) return 1;
        if (f[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f, input logic [31:0] a);
        int sz, base;
        logic [3:0] be;
        sz   = ref_size(f);
        base = (sz == 1) ? int'(a[1:0]) : (sz == 2) ? 2 * int'(a[1]) : 0;
        for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + sz);
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f, input logic [31:0] d);
        if (ref_size(f) == 1) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (ref_size(f) == 2) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] d);
        logic [31:0] v;
        if (ref_size(f) == 1) begin
            v = (d >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
            if (!f[2] && v[7]) v = v | 32'hFFFF_FF00;
        end else if (ref_size(f) == 2) begin
            v = (d >> (16 * int'(a[1]))) & 32'h0000_FFFF;
            if (!f[2] && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    // Issue one op, play the memory side, push the expectation, record what the DUT did.
    // gnt_dly: REQ cycles without grant (-1 = never); rv_dly: cycles from grant to rvalid.
    task automatic do_op(input logic op_we, input logic [2:0] op_f3, input logic [31:0] op_addr,
                         input logic [31:0] op_wd, input int gnt_dly, input int rv_dly,
                         input logic [31:0] mrd, input bit poke);
        exp_t e;
        bit   no_acc, tmo;
        int   gnt_k;
        e.fault = ref_fault(op_we, op_f3);
        e.mis   = ref_mis(op_f3, op_addr) && !e.fault;
        no_acc  = e.fault || e.mis;
        tmo     = !no_acc && (gnt_dly < 0 || gnt_dly >= TO || (!op_we && gnt_dly + rv_dly >= TO));
        if (tmo) e.fault = 1'b1;
        e.rdata = (no_acc || tmo || op_we) ? 32'd0 : ref_load(op_f3, op_addr, mrd);
        exp_lat = no_acc ? 1 : tmo ? TO + 1 : op_we ? gnt_dly + 2 : gnt_dly + rv_dly + 2;
        sb.push_back(e);
        obs_done = 0; obs_unstable = 0; obs_req_n = 0; obs_lat = 0; gnt_k = 0;
        start = 1'b1; we = op_we; f3 = op_f3; addr = op_addr; wdata = op_wd;
        for (int k = 1; k <= 64; k++) begin
            @(posedge clk); #1;
            start = 1'b0; gnt = 1'b0; rvalid = 1'b0;
            if (poke && busy) begin
                start = (k % 2 == 1); we = ~op_we; f3 = 3'd0;
                addr = $urandom(); wdata = $urandom();
            end
            if (mem_req) begin
                obs_req_n++;
                if (obs_req_n == 1) begin
                    obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata; obs_we = mem_we;
                end else if (mem_addr !== obs_addr || mem_be !== obs_be ||
                             mem_wdata !== obs_wdata || mem_we !== obs_we) begin
                    obs_unstable = 1;
                end
                if (obs_req_n - 1 == gnt_dly) begin
                    gnt = 1'b1; gnt_k = k;
                end
            end
            if (!op_we && gnt_k > 0 && k == gnt_k + rv_dly) rvalid = 1'b1;
            mem_rdata = rvalid ? mrd : $urandom();
            if (done) begin
                obs_done = 1; obs_lat = k; obs_rdata = rdata; obs_fault = fault; obs_mis = misalign;
                break;
            end
        end
        start = 1'b0; gnt = 1'b0; rvalid = 1'b0; we = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_ctl: busy/done/req=%b%b%b expected 000", busy, done, mem_req);
        end
        n_checks++;
        if (rdata !== 32'd0 || mem_be !== 4'd0 || mem_addr !== 32'd0) begin
            n_fail++; $display("FAIL reset_data: rdata=%h be=%h addr=%h expected 0", rdata, mem_be, mem_addr);
        end
        n_checks++;
        if (fault !== 1'b0 || misalign !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: fault=%b misalign=%b expected 0", fault, misalign);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb();
        exp_t e;
        do_op(1'b0, 3'b000, 32'h0000_0103, 32'd0, 0, 0, 32'h8022_3344, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (!obs_done || obs_rdata !== e.rdata || obs_fault !== e.fault || obs_mis !== e.mis) begin
            n_fail++; $display("FAIL lb_sb: done=%0d rdata=%h f=%b m=%b expected %h %b %b",
                               obs_done, obs_rdata, obs_fault, obs_mis, e.rdata, e.fault, e.mis);
        end
        n_checks++;
        if (obs_rdata !== 32'hFFFF_FF80 || obs_lat != 2) begin
            n_fail++; $display("FAIL lb_value: rdata=%h lat=%0d expected ffffff80 lat 2", obs_rdata, obs_lat);
        end
        n_checks++;
        if (obs_addr !== 32'h100 || obs_be !== 4'b1000 || obs_we !== 1'b0) begin
            n_fail++; $display("FAIL lb_port: addr=%h be=%b we=%b expected 100 1000 0", obs_addr, obs_be, obs_we);
        end
    endtask

    task automatic test_sh();
        exp_t e;
        do_op(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 3, 0, 32'd0, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (!obs_done || obs_rdata !== e.rdata || obs_fault !== e.fault || obs_mis !== e.mis) begin
            n_fail++; $display("FAIL sh_sb: done=%0d rdata=%h f=%b m=%b expected %h %b %b",
                               obs_done, obs_rdata, obs_fault, obs_mis, e.rdata, e.fault, e.mis);
        end
        n_checks++;
        if (obs_wdata !== 32'hABCD_ABCD || obs_be !== 4'b1100 || obs_we !== 1'b1) begin
            n_fail++; $display("FAIL sh_port: wdata=%h be=%b we=%b expected abcdabcd 1100 1",
                               obs_wdata, obs_be, obs_we);
        end
        n_checks++;
        if (obs_req_n != 4 || obs_lat != exp_lat || obs_unstable) begin
            n_fail++; $display("FAIL sh_timing: req=%0d lat=%0d unstable=%0d expected 4 %0d 0",
                               obs_req_n, obs_lat, obs_unstable, exp_lat);
        end
    endtask

    task automatic test_lhu_busy_start();
        exp_t e;
        do_op(1'b0, 3'b101, 32'h0000_0006, 32'd0, 0, 2, 32'hBEEF_0000, 1'b1);
        e = sb.pop_front();
        n_checks++;
        if (!obs_done || obs_rdata !== e.rdata || obs_fault !== e.fault || obs_mis !== e.mis) begin
            n_fail++; $display("FAIL lhu_sb: done=%0d rdata=%h f=%b m=%b expected %h %b %b",
                               obs_done, obs_rdata, obs_fault, obs_mis, e.rdata, e.fault, e.mis);
        end
        n_checks++;
        if (obs_rdata !== 32'h0000_BEEF || obs_lat != 4 || obs_unstable) begin
            n_fail++; $display("FAIL lhu_value: rdata=%h lat=%0d unstable=%0d expected 0000beef 4 0",
                               obs_rdata, obs_lat, obs_unstable);
        end
        n_checks++;
        if (busy !== 1'b0 || rdata !== 32'h0000_BEEF) begin
            n_fail++; $display("FAIL lhu_after: busy=%b rdata=%h expected 0 0000beef", busy, rdata);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        do_op(1'b0, 3'b010, 32'h0000_0040, 32'd0, -1, 0, 32'h1111_2222, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (!obs_done || obs_rdata !== e.rdata || obs_fault !== e.fault || obs_mis !== e.mis) begin
            n_fail++; $display("FAIL timeout_sb: done=%0d rdata=%h f=%b m=%b expected %h %b %b",
                               obs_done, obs_rdata, obs_fault, obs_mis, e.rdata, e.fault, e.mis);
        end
        n_checks++;
        if (obs_req_n != TO || obs_lat != TO + 1 || obs_fault !== 1'b1) begin
            n_fail++; $display("FAIL timeout_timing: req=%0d lat=%0d fault=%b expected %0d %0d 1",
                               obs_req_n, obs_lat, obs_fault, TO, TO + 1);
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        logic [2:0] bad [2];
        bad[0] = 3'b011;
        bad[1] = 3'b100;
        for (int i = 0; i < 2; i++) begin
            do_op(logic'(i), bad[i], 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 32'h5555_5555, 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (!obs_done || obs_fault !== e.fault || obs_rdata !== e.rdata || obs_mis !== e.mis) begin
                n_fail++; $display("FAIL illegal_sb[%0d]: done=%0d f=%b rdata=%h m=%b expected %b %h %b",
                                   i, obs_done, obs_fault, obs_rdata, obs_mis, e.fault, e.rdata, e.mis);
            end
            n_checks++;
            if (obs_req_n != 0 || obs_lat != 1 || obs_fault !== 1'b1) begin
                n_fail++; $display("FAIL illegal_timing[%0d]: req=%0d lat=%0d fault=%b expected 0 1 1",
                                   i, obs_req_n, obs_lat, obs_fault);
            end
        end
    endtask

    task automatic test_misalign();
        exp_t e;
        do_op(1'b0, 3'b010, 32'h0000_0101, 32'd0, 0, 0, 32'hCAFE_F00D, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (!obs_done || obs_rdata !== e.rdata || obs_fault !== e.fault || obs_mis !== e.mis) begin
            n_fail++; $display("FAIL misalign_sb: done=%0d rdata=%h f=%b m=%b expected %h %b %b",
                               obs_done, obs_rdata, obs_fault, obs_mis, e.rdata, e.fault, e.mis);
        end
        n_checks++;
`ifdef LSU_MISALIGN_CHECK_EN
        if (obs_req_n != 0 || obs_lat != 1 || obs_mis !== 1'b1) begin
            n_fail++; $display("FAIL misalign_trap: req=%0d lat=%0d mis=%b expected 0 1 1",
                               obs_req_n, obs_lat, obs_mis);
        end
`else
        if (obs_addr !== 32'h100 || obs_be !== 4'b1111 || obs_lat != 2) begin
            n_fail++; $display("FAIL misalign_trunc: addr=%h be=%b lat=%0d expected 100 1111 2",
                               obs_addr, obs_be, obs_lat);
        end
`endif
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [2:0]  tbl [5];
        logic        w;
        logic [2:0]  f;
        logic [31:0] a, d;
        tbl[0] = 3'd0; tbl[1] = 3'd1; tbl[2] = 3'd2; tbl[3] = 3'd4; tbl[4] = 3'd5;
        for (int i = 0; i < 14; i++) begin
            w = logic'($urandom_range(0, 1));
            f = tbl[$urandom_range(0, w ? 2 : 4)];
            a = $urandom();
            d = $urandom();
            do_op(w, f, a, d, $urandom_range(0, 2), $urandom_range(0, 1), $urandom(), 1'b0);
            e = sb.pop_front();
            n_checks++;
            if (!obs_done || obs_rdata !== e.rdata || obs_fault !== e.fault ||
                obs_mis !== e.mis || obs_lat != exp_lat) begin
                n_fail++; $display("FAIL b2b_sb[%0d]: rdata=%h f=%b m=%b lat=%0d expected %h %b %b %0d",
                                   i, obs_rdata, obs_fault, obs_mis, obs_lat,
                                   e.rdata, e.fault, e.mis, exp_lat);
            end
            if (!e.mis) begin
                n_checks++;
                if (obs_addr !== {a[31:2], 2'b00} || obs_be !== ref_be(f, a) || obs_we !== w ||
                    (w && obs_wdata !== ref_wdata(f, d))) begin
                    n_fail++; $display("FAIL b2b_port[%0d]: addr=%h be=%b we=%b wd=%h expected %h %b %b %h",
                                       i, obs_addr, obs_be, obs_we, obs_wdata,
                                       {a[31:2], 2'b00}, ref_be(f, a), w, ref_wdata(f, d));
                end
            end
        end
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        start = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0000_0010;
        @(posedge clk); #1;
        start = 1'b0;
        gnt = mem_req;
        @(posedge clk); #1;
        gnt = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++; $display("FAIL wait_entry: busy=%b req=%b expected 1 0", busy, mem_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || rdata !== 32'd0 || done !== 1'b0) begin
            n_fail++; $display("FAIL wait_reset: busy=%b req=%b rdata=%h done=%b expected 0 0 0 0",
                               busy, mem_req, rdata, done);
        end
        rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        rvalid = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || rdata !== 32'd0) begin
            n_fail++; $display("FAIL late_rvalid: done=%b busy=%b rdata=%h expected 0 0 0", done, busy, rdata);
        end
        do_op(1'b0, 3'b010, 32'h0000_0020, 32'd0, 0, 1, 32'h0BAD_CAFE, 1'b0);
        e = sb.pop_front();
        n_checks++;
        if (!obs_done || obs_rdata !== e.rdata || obs_fault !== e.fault || obs_lat != 3) begin
            n_fail++; $display("FAIL post_reset_lw: done=%0d rdata=%h f=%b lat=%0d expected %h %b 3",
                               obs_done, obs_rdata, obs_fault, obs_lat, e.rdata, e.fault);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; we = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        gnt = 1'b0; rvalid = 1'b0; mem_rdata = 32'd0;
        test_reset();
        test_lb();
        test_sh();
        test_lhu_busy_start();
        test_timeout();
        test_illegal();
        test_misalign();
        test_back_to_back();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
